// File: rtl/cond_alu_seq_if.sv
// cond_alu_seq_if: bundles the instruction handshake and the result
// handshake of the sequential conditional ALU.
//   master : decode-side view (drives the instruction, consumes the result)
//   slave  : ALU-side view (accepts the instruction, presents the result)
// Signals:
//   in_valid/in_ready   instruction handshake
//   cond, opcode, a, b, imm  instruction fields
//   out_valid/out_ready result handshake
//   result, result_we, skipped, flags  registered result and committed flags
interface cond_alu_seq_if #(
  parameter int W  = 16,
  parameter int IW = 7
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    cond;
  logic [3:0]    opcode;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [IW-1:0] imm;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          result_we;
  logic          skipped;
  logic [3:0]    flags;

  modport master (
    output in_valid, cond, opcode, a, b, imm, out_ready,
    input  in_ready, out_valid, result, result_we, skipped, flags
  );

  modport slave (
    input  in_valid, cond, opcode, a, b, imm, out_ready,
    output in_ready, out_valid, result, result_we, skipped, flags
  );
endinterface

// File: rtl/cond_alu_seq.sv
// cond_alu_seq: sequential conditional ALU. Accepts one instruction per
// handshake, evaluates its 2-bit condition against the committed flags,
// executes single-cycle ops directly or a W-cycle shift-add multiply, and
// holds a registered result until the consumer takes it.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  cond_alu_seq_if slave modport (instruction in, result out)
// Flags are packed {Z,N,C,V}.
module cond_alu_seq #(
  parameter int W  = 16,
  parameter int IW = 7
) (
  input logic           clk,
  input logic           rst,
  cond_alu_seq_if.slave bus
);

  localparam int SW = $clog2(W);
  localparam logic [3:0] OP_MUL = 4'h2;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  typedef enum logic [1:0] {FK_NONE, FK_ADD, FK_SUB, FK_LOGIC} flag_kind_t;

  state_t          state;
  logic            out_valid_q;
  logic [W-1:0]    result_q;
  logic            we_q;
  logic            skipped_q;
  logic [3:0]      flags_q;

  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  mcand;
  logic [W-1:0]    mplier;
  logic [SW-1:0]   cnt;

  logic            accept;
  logic            cond_ok;
  logic [W:0]      add_w;
  logic [W:0]      sub_w;
  logic            add_v;
  logic            sub_v;
  logic [W-1:0]    imm_ext;
  logic [SW-1:0]   s;
  logic [W-1:0]    op_res;
  logic            op_we;
  logic [3:0]      op_flags;
  flag_kind_t      fk;
  logic [2*W-1:0]  acc_next;
  logic [3:0]      mul_flags;

  // Handshake: idle always takes work; a finished result can be retired and
  // replaced in the same cycle, so DONE forwards out_ready.
  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result_we = we_q;
  assign bus.skipped   = skipped_q;
  assign bus.flags     = flags_q;

  // Condition against the committed flags; a back-to-back instruction sees
  // the flags of the result currently being retired.
  always_comb begin
    cond_ok = 1'b1;
    case (bus.cond)
      2'b01:   cond_ok = flags_q[3];
      2'b10:   cond_ok = !flags_q[3];
      2'b11:   cond_ok = flags_q[2] ^ flags_q[0];
      default: cond_ok = 1'b1;
    endcase
  end

  // Single-cycle datapath. Adder and subtractor carry an extra bit so the
  // carry/borrow comes straight out of the top bit.
  always_comb begin
    add_w   = {1'b0, bus.a} + {1'b0, bus.b};
    sub_w   = {1'b0, bus.a} - {1'b0, bus.b};
    add_v   = (bus.a[W-1] == bus.b[W-1]) && (add_w[W-1] != bus.a[W-1]);
    sub_v   = (bus.a[W-1] != bus.b[W-1]) && (sub_w[W-1] != bus.a[W-1]);
    imm_ext = '0;
    imm_ext[IW-1:0] = bus.imm;
    s       = bus.imm[SW-1:0];
    op_res  = '0;
    op_we   = 1'b1;
    fk      = FK_NONE;
    case (bus.opcode)
      4'h0: begin op_res = add_w[W-1:0]; fk = FK_ADD; end
      4'h1: begin op_res = sub_w[W-1:0]; fk = FK_SUB; end
      4'h3: begin op_res = bus.a | bus.b; fk = FK_LOGIC; end
      4'h4: begin op_res = bus.a & bus.b; fk = FK_LOGIC; end
      4'h5: begin op_res = bus.a ^ bus.b; fk = FK_LOGIC; end
      4'h6: op_res = imm_ext;
      4'h7: op_res = bus.a;
      4'h8: op_res = bus.a >> s;
      4'h9: op_res = bus.a << s;
      // With s = 0 the left shift by W yields zero, leaving a unchanged.
      4'hA: op_res = (bus.a >> s) | (bus.a << (W - int'(s)));
      4'hB: begin op_res = sub_w[W-1:0]; op_we = 1'b0; fk = FK_SUB; end
      4'hC: op_res = imm_ext;
      4'hD: op_res = bus.a;
      4'hE: begin op_res = bus.a; op_we = 1'b0; end
      4'hF: begin op_res = '0; op_we = 1'b0; end
      default: op_res = '0;
    endcase
    case (fk)
      FK_ADD:   op_flags = {~|add_w[W-1:0], add_w[W-1], add_w[W], add_v};
      FK_SUB:   op_flags = {~|sub_w[W-1:0], sub_w[W-1], sub_w[W], sub_v};
      FK_LOGIC: op_flags = {~|op_res, op_res[W-1], 2'b00};
      default:  op_flags = flags_q;
    endcase
  end

  // One multiplier bit per cycle; the multiplicand walks left through a
  // double-width register so the accumulator holds the full product.
  always_comb begin
    acc_next  = mplier[0] ? (acc + mcand) : acc;
    mul_flags = {~|acc_next[W-1:0], acc_next[W-1],
                 |acc_next[2*W-1:W], |acc_next[2*W-1:W]};
  end

  // Control FSM. Acceptance takes priority: it can happen from IDLE or from
  // DONE while the previous result is being retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      we_q        <= 1'b0;
      skipped_q   <= 1'b0;
      flags_q     <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
    end else if (accept) begin
      if (!cond_ok) begin
        result_q    <= '0;
        we_q        <= 1'b0;
        skipped_q   <= 1'b1;
        out_valid_q <= 1'b1;
        state       <= DONE;
      end else if (bus.opcode == OP_MUL) begin
        mcand       <= {{W{1'b0}}, bus.a};
        mplier      <= bus.b;
        acc         <= '0;
        cnt         <= '0;
        out_valid_q <= 1'b0;
        state       <= MUL;
      end else begin
        result_q    <= op_res;
        we_q        <= op_we;
        skipped_q   <= 1'b0;
        flags_q     <= op_flags;
        out_valid_q <= 1'b1;
        state       <= DONE;
      end
    end else begin
      case (state)
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          // The last iteration registers its own accumulation directly.
          if (cnt == SW'(W - 1)) begin
            result_q    <= acc_next[W-1:0];
            we_q        <= 1'b1;
            skipped_q   <= 1'b0;
            flags_q     <= mul_flags;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cond_alu_seq.sv
// tb_cond_alu_seq: self-checking bench for cond_alu_seq. A W=16 instance is
// exercised with a directed vector table, hand-written handshake/reset
// sequences and random instructions checked against an arithmetic reference
// model; a W=8 instance covers the narrow-parameter multiply.
module tb_cond_alu_seq;

  localparam int W  = 16;
  localparam int IW = 7;

  typedef struct {
    logic [15:0] res;
    logic        we;
    logic        skip;
    logic [3:0]  fl;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  cnd;
    logic [15:0] a;
    logic [15:0] b;
    logic [6:0]  imm;
    logic [15:0] res;
    logic        we;
    logic        skip;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] mflags;
  vec_t vecs[$];

  always #5 clk = ~clk;

  cond_alu_seq_if #(.W(W), .IW(IW)) bus ();
  cond_alu_seq_if #(.W(8), .IW(4))  bus8 ();

  cond_alu_seq #(.W(W), .IW(IW)) dut  (.clk(clk), .rst(rst), .bus(bus));
  cond_alu_seq #(.W(8), .IW(4))  dut8 (.clk(clk), .rst(rst), .bus(bus8));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Reference model: plain integer arithmetic on the 16-bit instance.
  function automatic exp_t model(input logic [3:0] op, input logic [1:0] cnd,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [6:0] imm, input logic [3:0] fl);
    exp_t   e;
    longint ua, ub, sa, sb, full, r, sr;
    int     sh;
    bit     pass, c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    sh = int'(imm) % 16;
    case (cnd)
      2'd0:    pass = 1'b1;
      2'd1:    pass = fl[3];
      2'd2:    pass = !fl[3];
      default: pass = fl[2] ^ fl[0];
    endcase
    e.res = '0; e.we = 1'b0; e.skip = 1'b1; e.fl = fl; e.lat = 1;
    if (!pass) return e;
    e.skip = 1'b0;
    e.we   = !(op inside {4'hB, 4'hE, 4'hF});
    c = fl[1];
    v = fl[0];
    r = 0;
    case (op)
      4'h0: begin
        full = ua + ub; r = full % 65536; c = (full > 65535);
        sr = sa + sb; v = (sr > 32767) || (sr < -32768);
      end
      4'h1, 4'hB: begin
        full = ua - ub; r = (full + 65536) % 65536; c = (ua < ub);
        sr = sa - sb; v = (sr > 32767) || (sr < -32768);
      end
      4'h2: begin
        full = ua * ub; r = full % 65536; c = (full > 65535); v = c; e.lat = 17;
      end
      4'h3: begin r = ua | ub; c = 1'b0; v = 1'b0; end
      4'h4: begin r = ua & ub; c = 1'b0; v = 1'b0; end
      4'h5: begin r = ua ^ ub; c = 1'b0; v = 1'b0; end
      4'h6, 4'hC: r = longint'(imm);
      4'h7, 4'hD, 4'hE: r = ua;
      4'h8: r = ua / (64'sd1 << sh);
      4'h9: r = (ua * (64'sd1 << sh)) % 65536;
      4'hA: begin
        r = ua;
        for (int k = 0; k < sh; k++) r = (r / 2) + (r % 2) * 32768;
      end
      default: r = 0;
    endcase
    e.res = 16'(r);
    if (op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hB})
      e.fl = {r == 0, r >= 32768, c, v};
    return e;
  endfunction

  task automatic addVec(input logic [3:0] op, input logic [1:0] cnd, input logic [15:0] a,
                        input logic [15:0] b, input logic [6:0] imm, input logic [15:0] res,
                        input logic we, input logic skip, input logic [3:0] fl, input int lat);
    vec_t v;
    v.op = op; v.cnd = cnd; v.a = a; v.b = b; v.imm = imm;
    v.res = res; v.we = we; v.skip = skip; v.fl = fl; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Issues one instruction, measures latency (edges counted from the one
  // that takes the handshake), checks the result, holds it for `stall`
  // cycles of backpressure and then retires it.
  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [1:0] cnd,
                               input logic [15:0] a, input logic [15:0] b, input logic [6:0] imm,
                               input exp_t e, input int stall);
    int lat;
    int busy;
    int guard;
    bus.opcode = op; bus.cond = cnd; bus.a = a; bus.b = b; bus.imm = imm;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    guard = 0;
    while (!bus.in_ready && guard < 64) begin
      @(posedge clk); #1; guard++;
    end
    if (!bus.in_ready) begin
      reportTimeout({tag, " in_ready"});
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    busy = 0;
    while (!bus.out_valid && lat < 64) begin
      if (bus.in_ready) busy++;
      @(posedge clk); #1; lat++;
    end
    if (!bus.out_valid) begin
      reportTimeout({tag, " out_valid"});
      return;
    end
    checkOutput({tag, " latency"}, lat, e.lat);
    if (e.lat > 1) checkOutput({tag, " in_ready during MUL"}, busy, 0);
    if (e.skip || !(op inside {4'hB, 4'hF})) checkOutput({tag, " result"}, bus.result, e.res);
    checkOutput({tag, " result_we"}, bus.result_we, e.we);
    checkOutput({tag, " skipped"}, bus.skipped, e.skip);
    checkOutput({tag, " flags"}, bus.flags, e.fl);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      checkOutput({tag, " held out_valid"}, bus.out_valid, 1'b1);
      checkOutput({tag, " held in_ready"}, bus.in_ready, 1'b0);
      checkOutput({tag, " held flags"}, bus.flags, e.fl);
      if (e.skip || !(op inside {4'hB, 4'hF})) checkOutput({tag, " held result"}, bus.result, e.res);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, " retired"}, bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.opcode = '0; bus.cond = '0; bus.a = '0; bus.b = '0; bus.imm = '0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    bus8.opcode = '0; bus8.cond = '0; bus8.a = '0; bus8.b = '0; bus8.imm = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mflags = 4'h0;
  endtask

  task automatic apply8(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] res, input logic [3:0] fl,
                        input int lat_req);
    int lat;
    bus8.opcode = op; bus8.cond = 2'b00; bus8.a = a; bus8.b = b; bus8.imm = '0;
    bus8.in_valid = 1'b1;
    bus8.out_ready = 1'b0;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 1;
    while (!bus8.out_valid && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus8.out_valid) begin
      reportTimeout({tag, " out_valid"});
    end else begin
      checkOutput({tag, " latency"}, lat, lat_req);
      checkOutput({tag, " result"}, bus8.result, res);
      checkOutput({tag, " flags"}, bus8.flags, fl);
      checkOutput({tag, " result_we"}, bus8.result_we, 1'b1);
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int   seen;
    logic [3:0]  op;
    logic [1:0]  cnd;
    logic [15:0] a, b;
    logic [6:0]  imm;

    doReset();
    checkOutput("reset out_valid", bus.out_valid, 1'b0);
    checkOutput("reset result", bus.result, 16'h0);
    checkOutput("reset result_we", bus.result_we, 1'b0);
    checkOutput("reset skipped", bus.skipped, 1'b0);
    checkOutput("reset flags", bus.flags, 4'h0);
    checkOutput("reset in_ready", bus.in_ready, 1'b1);

    // Directed table, applied in order; flags chain from one entry to the next.
    addVec(4'h0, 2'b00, 16'h7FFF, 16'h0001, 7'h00, 16'h8000, 1, 0, 4'b0101, 1);
    addVec(4'h1, 2'b00, 16'h0003, 16'h0005, 7'h00, 16'hFFFE, 1, 0, 4'b0110, 1);
    addVec(4'hB, 2'b00, 16'h1234, 16'h1234, 7'h00, 16'h0000, 0, 0, 4'b1000, 1);
    addVec(4'h0, 2'b10, 16'h0001, 16'h0001, 7'h00, 16'h0000, 0, 1, 4'b1000, 1);
    addVec(4'h0, 2'b01, 16'h0001, 16'h0002, 7'h00, 16'h0003, 1, 0, 4'b0000, 1);
    addVec(4'hA, 2'b00, 16'h8001, 16'h0000, 7'h01, 16'hC000, 1, 0, 4'b0000, 1);
    addVec(4'hA, 2'b00, 16'h8001, 16'h0000, 7'h00, 16'h8001, 1, 0, 4'b0000, 1);
    addVec(4'h9, 2'b00, 16'h0001, 16'h0000, 7'h0F, 16'h8000, 1, 0, 4'b0000, 1);
    addVec(4'h5, 2'b00, 16'hFFFF, 16'h0F0F, 7'h00, 16'hF0F0, 1, 0, 4'b0100, 1);
    addVec(4'h6, 2'b11, 16'h0000, 16'h0000, 7'h7F, 16'h007F, 1, 0, 4'b0100, 1);
    addVec(4'h4, 2'b00, 16'h00F0, 16'h0F00, 7'h00, 16'h0000, 1, 0, 4'b1000, 1);
    addVec(4'h7, 2'b11, 16'h1234, 16'h0000, 7'h00, 16'h0000, 0, 1, 4'b1000, 1);
    addVec(4'hE, 2'b00, 16'hABCD, 16'h5555, 7'h00, 16'hABCD, 0, 0, 4'b1000, 1);
    addVec(4'hC, 2'b00, 16'h0000, 16'h0000, 7'h55, 16'h0055, 1, 0, 4'b1000, 1);
    addVec(4'h2, 2'b00, 16'h0100, 16'h0100, 7'h00, 16'h0000, 1, 0, 4'b1011, 17);
    addVec(4'h8, 2'b00, 16'h8000, 16'h0000, 7'h04, 16'h0800, 1, 0, 4'b1011, 1);
    addVec(4'hD, 2'b00, 16'h2000, 16'h0000, 7'h00, 16'h2000, 1, 0, 4'b1011, 1);
    addVec(4'h3, 2'b00, 16'h8000, 16'h0001, 7'h00, 16'h8001, 1, 0, 4'b0100, 1);
    addVec(4'hF, 2'b00, 16'h0000, 16'h0000, 7'h00, 16'h0000, 0, 0, 4'b0100, 1);
    addVec(4'h1, 2'b00, 16'h8000, 16'h0001, 7'h00, 16'h7FFF, 1, 0, 4'b0001, 1);
    addVec(4'h0, 2'b00, 16'hFFFF, 16'h0001, 7'h00, 16'h0000, 1, 0, 4'b1010, 1);
    for (int i = 0; i < vecs.size(); i++) begin
      e.res = vecs[i].res; e.we = vecs[i].we; e.skip = vecs[i].skip;
      e.fl = vecs[i].fl; e.lat = vecs[i].lat;
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].cnd, vecs[i].a,
                    vecs[i].b, vecs[i].imm, e, (i % 4 == 1) ? 2 : 0);
    end

    // Backpressure on MOVI, then retire and accept in the same cycle.
    doReset();
    bus.opcode = 4'h6; bus.cond = 2'b00; bus.imm = 7'h7F; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("bp out_valid", bus.out_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput("bp held result", bus.result, 16'h007F);
      checkOutput("bp in_ready low", bus.in_ready, 1'b0);
    end
    bus.opcode = 4'h0; bus.a = 16'hFFFF; bus.b = 16'h0001; bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bp in_ready follows out_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("b2b out_valid", bus.out_valid, 1'b1);
    checkOutput("b2b result", bus.result, 16'h0000);
    checkOutput("b2b flags", bus.flags, 4'b1010);
    @(posedge clk); #1;
    checkOutput("b2b retired", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;

    // Reset in the middle of a multiply: the result must never appear.
    bus.opcode = 4'h2; bus.a = 16'h0003; bus.b = 16'h0005; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("mid-MUL busy", bus.in_ready, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("abort out_valid", bus.out_valid, 1'b0);
    checkOutput("abort flags", bus.flags, 4'h0);
    checkOutput("abort result", bus.result, 16'h0);
    #3 rst = 1'b0;
    #1;
    checkOutput("abort in_ready", bus.in_ready, 1'b1);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checkOutput("abort no result", seen, 0);
    bus.out_ready = 1'b0;

    // Back-to-back stream at full throughput against the model.
    doReset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op  = 4'($urandom_range(0, 15));
      if (op == 4'h2) op = 4'h5;
      cnd = 2'($urandom_range(0, 3));
      a   = 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      imm = 7'($urandom);
      bus.opcode = op; bus.cond = cnd; bus.a = a; bus.b = b; bus.imm = imm;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      e = model(op, cnd, a, b, imm, mflags);
      checkOutput($sformatf("stream%0d out_valid", i), bus.out_valid, 1'b1);
      if (e.skip || !(op inside {4'hB, 4'hF}))
        checkOutput($sformatf("stream%0d result", i), bus.result, e.res);
      checkOutput($sformatf("stream%0d result_we", i), bus.result_we, e.we);
      checkOutput($sformatf("stream%0d skipped", i), bus.skipped, e.skip);
      checkOutput($sformatf("stream%0d flags", i), bus.flags, e.fl);
      mflags = e.fl;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("stream drained", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;

    // Random single instructions, including multiplies and backpressure.
    for (int i = 0; i < 60; i++) begin
      op  = 4'($urandom_range(0, 15));
      cnd = 2'($urandom_range(0, 3));
      a   = 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      imm = 7'($urandom);
      e = model(op, cnd, a, b, imm, mflags);
      applyStimulus($sformatf("rand%0d", i), op, cnd, a, b, imm, e, $urandom_range(0, 2));
      mflags = e.fl;
    end

    // Narrow instance: W=8, IW=4.
    doReset();
    apply8("w8 MUL", 4'h2, 8'h0F, 8'h11, 8'hFF, 4'b0100, 9);
    apply8("w8 ADD", 4'h0, 8'h80, 8'h80, 8'h00, 4'b1011, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_alu_seq.md
# cond_alu_seq

Parametrised, sequential successor to the combinational ALU. It accepts one conditional instruction per handshake and evaluates the 2-bit condition against an internal flags register. It executes single-cycle ops, or an iterative shift-add multiply, and presents a registered result with a register-write enable. It sits between the decode stage and the register-file write port; memory opcodes only form the address/data that the load/store unit consumes.

## Interface
- W, 16: datapath width (≥4).
- IW, 7: immediate width (≤W), zero-extended.
- SW, $clog2(W): shift-amount width, taken from imm[SW-1:0].
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  instruction accepted when in_valid & in_ready.
- cond  in  2  00 always, 01 EQ (Z), 10 NE (!Z), 11 LT (N^V).
- opcode  in  4  operation, encoding below.
- a, b  in  W  operands Reg1, Reg2.
- imm  in  IW  constant / shift amount.
- out_valid  out  1  result held until out_valid & out_ready.
- out_ready  in  1  consumer accepts result.
- result  out  W  registered result.
- result_we  out  1  destination write required.
- skipped  out  1  condition failed; instruction squashed.
- flags  out  4  {Z,N,C,V} committed flags.

## Operation
- Opcodes: 0 ADD a+b; 1 SUB a-b; 2 MUL low W bits of a*b; 3 OR; 4 AND; 5 XOR; 6 MOVI zext(imm); 7 MOV a; 8 SHR a>>s logical; 9 SHL a<<s; A ROR a by s; B CMP (a-b, flags only); C LDA zext(imm); D LD addr=a; E ST addr=a; F NOP.
- result_we = 1 for 0–A and C/D. It is 0 for B, E and F, and 0 for any skipped instruction. For E, result = a; the store data b is passed on by decode.
- Condition is evaluated at acceptance against committed flags. On failure: result=0, result_we=0, skipped=1, flags unchanged, latency one cycle regardless of opcode.
- Flags, committed when the result registers:
  - ADD: Z, N, C = carry-out, V = signed overflow.
  - SUB/CMP: Z, N, C = borrow (a<b unsigned), V = signed overflow.
  - MUL: Z and N of low half; C = V = (high half ≠ 0).
  - OR/AND/XOR: Z and N updated, C = V = 0.
  - All other ops: flags unchanged.
- s = 0 passes a unchanged for SHR, SHL and ROR.
- FSM:
  - IDLE: in_ready=1.
    - Accepted MUL with passing condition → MUL. Load a into the multiplicand, b into the multiplier, clear a 2W accumulator and a counter.
    - Any other accepted instruction → DONE with result registered.
  - MUL: one multiplier bit per cycle. Advance to DONE after W iterations, registering the result and flags.
  - DONE: out_valid=1; outputs stable.
    - out_ready=1 and in_valid=0 → IDLE.
    - out_ready=1 and in_valid=1 → accept the new instruction in the same cycle (in_ready = out_ready in DONE), then → DONE or MUL as above.
- The inputs a, b, imm, opcode and cond are sampled only on acceptance.

## Timing
- Reset: state IDLE, out_valid=0, result=0, result_we=0, skipped=0, flags=0000, accumulator and counter 0. in_ready=1 once rst deasserts.
- Non-MUL and skipped instructions: accepted at edge N, out_valid high after edge N+1.
- MUL: accepted at N, out_valid high after edge N+W+1.
- Throughput: one non-MUL op per cycle while out_ready stays high.
- Backpressure: result, result_we, skipped and flags are held while out_valid & !out_ready. in_ready=0 in MUL, and in DONE while out_ready=0.
- Back-to-back: the condition of an instruction accepted in DONE sees the flags of the instruction being retired, which are already committed.
- rst mid-MUL or in DONE: immediate abort to reset values; the pending result is lost and never emitted.
- Adder and subtractor are W+1 bits wide; the MUL accumulator is 2W bits. There is no truncation before flag extraction.

## Test plan
- Reset, then ADD a=0x7FFF b=0x0001 cond=00 → next cycle result=0x8000, result_we=1, flags Z0 N1 C0 V1.
- SUB a=0x0003 b=0x0005 → result=0xFFFE, C=1, N=1. Then CMP a=b=0x1234 → result_we=0, Z=1. Then ADD with cond=10 (NE) → skipped=1, result_we=0, flags unchanged.
- MUL a=0x0100 b=0x0100 (W=16) → out_valid exactly 17 cycles after acceptance, result=0x0000, Z=1, C=V=1, in_ready=0 throughout.
- ROR a=0x8001, imm=1 → 0xC000; with imm=0 → 0x8001. SHL a=0x0001, imm=15 → 0x8000, flags unchanged.
- Hold out_ready=0 for 5 cycles after MOVI imm=0x7F → result=0x007F held and in_ready=0. Raise out_ready with in_valid=1 → retire and accept in the same cycle.
- Assert rst at MUL iteration 8 → out_valid never rises, flags=0000, in_ready=1 after release. Rerun with W=8 / IW=4 parameters and a MUL of 0x0F*0x11 → 0xFF, C=0.
